// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the two-port RAM arbiter slice.
package ram_arb_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    typedef logic port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t port;
    } rd_tag_t;

    // Port id of a one-hot two-bit grant (bit 1 set means port 1).
    function automatic port_id_t grant_to_port(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Request/response bundle between the two RAM masters and the arbiter.
interface ram_port_arbiter_if;
    import ram_arb_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way arbiter: one-hot grant from the valids. ARB_ROUND_ROBIN_EN selects an
// alternating tie pointer; without it port 0 always wins a tie.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    port_id_t tie_port_s;

`ifdef ARB_ROUND_ROBIN_EN
    port_id_t ptr_r;

    // Tie pointer: after an accept it points at the port that lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= 1'b0;
        end else if (grant != 2'b00) begin
            ptr_r <= grant[0];
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign tie_port_s = ptr_r;
`else
    logic unused_s;

    assign unused_s   = clk;
    assign tie_port_s = 1'b0;
`endif

    // Grant decode; nothing is granted while reset is held.
    always_comb begin
        grant = 2'b00;
        if (reset) begin
            grant = 2'b00;
        end else begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = tie_port_s ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one 64x8 single-port RAM between two requesters; read data returns to the
// originating port two cycles after accept. Tie policy set by ARB_ROUND_ROBIN_EN.
module ram_port_arbiter
    import ram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    ram_port_arbiter_if.slave bus,
    output logic [DATA_W-1:0] ram_data_in,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_write_enable,
    input  logic [DATA_W-1:0] ram_data_out
);

    logic [1:0]        grant_s;
    logic              accept_s;
    port_id_t          sel_port_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              we_r;
    rd_tag_t           s1_r;
    rd_tag_t           s2_r;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .valid ({bus.req1_valid, bus.req0_valid}),
        .grant (grant_s)
    );

    assign accept_s       = (grant_s != 2'b00);
    assign sel_port_s     = grant_to_port(grant_s);
    assign bus.req0_ready = grant_s[0];
    assign bus.req1_ready = grant_s[1];

    // Request mux: pick the granted port's access.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        if (sel_port_s) begin
            sel_we_s    = bus.req1_we;
            sel_addr_s  = bus.req1_addr;
            sel_wdata_s = bus.req1_wdata;
        end else begin
            sel_we_s    = bus.req0_we;
            sel_addr_s  = bus.req0_addr;
            sel_wdata_s = bus.req0_wdata;
        end
    end

    // RAM pin registers: address/data hold when idle, write enable pulses one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            we_r    <= 1'b0;
        end else if (accept_s) begin
            addr_r  <= sel_addr_s;
            wdata_r <= sel_wdata_s;
            we_r    <= sel_we_s;
        end else begin
            we_r    <= 1'b0;
        end
    end

    // Read tag pipeline; s2 lines up with the RAM's registered read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_r <= '{valid: 1'b0, port: 1'b0};
            s2_r <= '{valid: 1'b0, port: 1'b0};
        end else begin
            s1_r <= '{valid: accept_s && !sel_we_s, port: sel_port_s};
            s2_r <= s1_r;
        end
    end

    assign ram_address      = addr_r;
    assign ram_data_in      = wdata_r;
    assign ram_write_enable = we_r;

    assign bus.rsp0_valid = s2_r.valid && (s2_r.port == 1'b0);
    assign bus.rsp1_valid = s2_r.valid && (s2_r.port == 1'b1);
    assign bus.rsp0_rdata = bus.rsp0_valid ? ram_data_out : {DATA_W{1'b0}};
    assign bus.rsp1_rdata = bus.rsp1_valid ? ram_data_out : {DATA_W{1'b0}};

endmodule
